// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, optional debounce,
// per-bit edge capture and a maskable level interrupt.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address: 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAP
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data (latency 1, updated every clk)
//   irq        registered level interrupt, active high
module pio_in_edge_irq #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_DIV = 0,
    parameter int unsigned EDGE_TYPE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Synchroniser chain; stage 0 is the metastability-exposed flop.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  filt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_DIV > 0) begin : g_debounce
        localparam int unsigned CntW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
        localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_DIV - 1);

        logic [CntW-1:0]  cnt_q, cnt_d;
        logic             tick;
        logic [WIDTH-1:0] samp_q, samp_d;
        logic [WIDTH-1:0] filt_q, filt_d;
        logic [WIDTH-1:0] stable;

        always_comb begin
            tick   = (cnt_q == CntMax);
            cnt_d  = tick ? '0 : cnt_q + CntW'(1);
            samp_d = tick ? sync : samp_q;
            // A bit follows sync only if it matched the sample from the previous tick.
            stable = ~(sync ^ samp_q);
            filt_d = filt_q;
            if (tick) begin
                filt_d = (sync & stable) | (filt_q & ~stable);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                samp_q <= '0;
                filt_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                samp_q <= samp_d;
                filt_q <= filt_d;
            end
        end

        assign filt = filt_q;
    end else begin : g_no_debounce
        assign filt = sync;
    end

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    logic [WIDTH-1:0] filt_dly_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = filt & ~filt_dly_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~filt & filt_dly_q;
        end else begin
            edge_det = filt ^ filt_dly_q;
        end

        wr_en      = chipselect & ~write_n;
        irq_mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
        clr        = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // OR-ing the new edge after the clear makes a simultaneous set win.
        edge_cap_d = (edge_cap_q & ~clr) | edge_det;
        irq_d      = |(edge_cap_q & irq_mask_q);

        readdata_d = '0;
        unique case (address)
            2'd0: readdata_d[WIDTH-1:0] = filt;
            2'd1: readdata_d            = '0;
            2'd2: readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3: readdata_d[WIDTH-1:0] = edge_cap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_dly_q <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            filt_dly_q <= filt;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: default config, a debounced config and an
// 8-bit any-edge config share one bus; each has its own inputs and outputs.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    logic [31:0] in_main = 32'hFFFF_FFFF;
    logic [31:0] in_db   = '0;
    logic [7:0]  in_any  = '0;
    logic [31:0] rd_main, rd_db, rd_any;
    logic        irq_main, irq_db, irq_any;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_DIV(0), .EDGE_TYPE(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_main),
        .readdata(rd_main), .irq(irq_main)
    );

    pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_DIV(4), .EDGE_TYPE(0)) u_dut_db (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_db),
        .readdata(rd_db), .irq(irq_db)
    );

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_DIV(0), .EDGE_TYPE(2)) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_any),
        .readdata(rd_any), .irq(irq_any)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; returns 1 time unit after the last rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Read data is valid one edge after the address is presented.
    task automatic bus_rd(input logic [1:0] a);
        address = a;
        step(1);
    endtask

    logic [31:0] acc;

    initial begin
        // T1: reset with all inputs high
        step(3);
        check_eq("rst_readdata", rd_main, 32'h0);
        check_eq("rst_irq", {31'b0, irq_main}, 32'h0);
        reset_n = 1'b1;
        step(2);
        check_eq("t1_data_early", rd_main, 32'h0);
        step(1);
        check_eq("t1_data", rd_main, 32'hFFFF_FFFF);

        // Clear reset-induced captures, then drop inputs: falling edges ignored
        bus_wr(2'd3, 32'hFFFF_FFFF);
        in_main = 32'h0;
        step(5);
        bus_rd(2'd3);
        check_eq("no_fall_cap", rd_main, 32'h0);

        // T2: rising capture on bit 0
        bus_wr(2'd2, 32'h1);
        in_main = 32'h1;
        step(3);
        check_eq("t2_irq_early", {31'b0, irq_main}, 32'h0);
        step(1);
        check_eq("t2_irq", {31'b0, irq_main}, 32'h1);
        bus_rd(2'd3);
        check_eq("t2_cap", rd_main, 32'h1);

        // T3: W1C in the same clk as a new bit0 edge
        in_main = 32'h0;
        step(4);
        in_main = 32'h1;
        step(2);
        bus_wr(2'd3, 32'h1);
        step(1);
        check_eq("t3_race_irq", {31'b0, irq_main}, 32'h1);
        bus_rd(2'd3);
        check_eq("t3_race_cap", rd_main, 32'h1);
        bus_wr(2'd3, 32'h1);
        check_eq("t3_clr_lag", {31'b0, irq_main}, 32'h1);
        step(1);
        check_eq("t3_clr_irq", {31'b0, irq_main}, 32'h0);

        // T4: masked edge on bit 5
        bus_wr(2'd2, 32'h0);
        in_main = 32'h21;
        step(5);
        bus_rd(2'd3);
        check_eq("t4_cap", rd_main, 32'h20);
        check_eq("t4_irq_masked", {31'b0, irq_main}, 32'h0);
        bus_wr(2'd2, 32'h20);
        check_eq("t4_irq_lag", {31'b0, irq_main}, 32'h0);
        step(1);
        check_eq("t4_irq", {31'b0, irq_main}, 32'h1);
        bus_rd(2'd2);
        check_eq("t4_mask_rd", rd_main, 32'h20);
        bus_rd(2'd1);
        check_eq("addr1_zero", rd_main, 32'h0);
        bus_wr(2'd0, 32'hDEAD_BEEF);
        bus_wr(2'd1, 32'hDEAD_BEEF);
        bus_rd(2'd0);
        check_eq("data_rd", rd_main, 32'h21);

        // T5: debounce, a 3-clk pulse is filtered out
        address = 2'd0;
        in_db   = 32'h4;
        step(3);
        in_db = 32'h0;
        acc   = '0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            acc |= rd_db;
        end
        check_eq("t5_pulse", acc, 32'h0);
        in_db = 32'h4;
        step(6);
        check_eq("t5_not_early", rd_db, 32'h0);
        step(6);
        check_eq("t5_stable", rd_db, 32'h4);

        // T6: any-edge on an 8-bit port
        in_any = 8'h80;
        step(5);
        bus_rd(2'd3);
        check_eq("t6_rise_cap", rd_any, 32'h80);
        bus_wr(2'd3, 32'h80);
        bus_rd(2'd3);
        check_eq("t6_cleared", rd_any, 32'h0);
        in_any = 8'h00;
        step(5);
        bus_rd(2'd3);
        check_eq("t6_fall_cap", rd_any, 32'h80);
        bus_wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd2);
        check_eq("t6_mask_any", rd_any, 32'hFF);
        check_eq("t6_mask_main", rd_main, 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a));
            check_eq("t6_upper_zero", rd_any & 32'hFFFF_FF00, 32'h0);
        end
        check_eq("t6_irq", {31'b0, irq_any}, 32'h1);
        check_eq("pre_rst_irq", {31'b0, irq_main}, 32'h1);

        // Asynchronous reset mid-cycle drops irq and readdata at once
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_irq", {31'b0, irq_main}, 32'h0);
        check_eq("async_rd", rd_main, 32'h0);
        step(2);
        reset_n = 1'b1;
        bus_rd(2'd2);
        check_eq("rst_mask", rd_main, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
